// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits on one shared segment bus.
// Shadows a hex word plus blank/dp masks on load, scans digits at a programmable rate.
module seven_segment_scanner #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic                      lz_suppress,
  output logic [6:0]                seg,
  output logic                      seg_dp,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic                      scan_tick
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic INV = (SEG_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                    scan_tick_q;
  logic                    wrap;

  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    cur_dp;
  logic                    cur_lz;
  logic                    upper_zero;
  logic [6:0]              seg_hi;
  logic                    dp_hi;
  logic [NUM_DIGITS-1:0]   en_hi;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Refresh divider, digit index and shadow capture
  always_comb begin
    wrap           = (div_cnt_q == CNT_LAST);
    div_cnt_d      = wrap ? '0 : div_cnt_q + CNT_W'(1);
    idx_d          = idx_q;
    shadow_data_d  = shadow_data_q;
    shadow_blank_d = shadow_blank_q;
    shadow_dp_d    = shadow_dp_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (load) begin
      shadow_data_d  = data;
      shadow_blank_d = blank;
      shadow_dp_d    = dp;
    end
  end

  // Current-digit select and leading-zero detection, scanning from the most significant digit
  always_comb begin
    cur_nib    = '0;
    cur_blank  = 1'b0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    upper_zero = 1'b1;
    en_hi      = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (shadow_data_q[4*k +: 4] == 4'h0);
      if (IDX_W'(k) == idx_q) begin
        cur_nib   = shadow_data_q[4*k +: 4];
        cur_blank = shadow_blank_q[k];
        cur_dp    = shadow_dp_q[k];
        cur_lz    = lz_suppress && (k != 0) && upper_zero;
        en_hi[k]  = 1'b1;
      end
    end

    seg_hi = hex_to_seg(cur_nib);
    dp_hi  = cur_dp;
    if (cur_blank) begin
      seg_hi = '0;
      dp_hi  = 1'b0;
      en_hi  = '0;
    end else if (cur_lz) begin
      // A suppressed zero keeps its decimal point, so the digit stays enabled only when dp is set
      seg_hi = '0;
      if (!cur_dp) begin
        en_hi = '0;
      end
    end

    seg_d      = seg_hi ^ {7{INV}};
    seg_dp_d   = dp_hi ^ INV;
    digit_en_d = en_hi ^ {NUM_DIGITS{INV}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q      <= '0;
      idx_q          <= '0;
      shadow_data_q  <= '0;
      shadow_blank_q <= '0;
      shadow_dp_q    <= '0;
      seg_q          <= {7{INV}};
      seg_dp_q       <= INV;
      digit_en_q     <= {NUM_DIGITS{INV}};
      scan_tick_q    <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      idx_q          <= idx_d;
      shadow_data_q  <= shadow_data_d;
      shadow_blank_q <= shadow_blank_d;
      shadow_dp_q    <= shadow_dp_d;
      seg_q          <= seg_d;
      seg_dp_q       <= seg_dp_d;
      digit_en_q     <= digit_en_d;
      scan_tick_q    <= wrap;
    end
  end

  assign seg       = seg_q;
  assign seg_dp    = seg_dp_q;
  assign digit_en  = digit_en_q;
  assign scan_tick = scan_tick_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: 4 digits, 4-clock dwell, active-low pins.
module tb_seven_segment_scanner;

  localparam int unsigned ND  = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned NV  = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   data = '0;
  logic [3:0]    blank = '0;
  logic [3:0]    dp = '0;
  logic          lz_suppress = 1'b0;
  logic [6:0]    seg;
  logic          seg_dp;
  logic [3:0]    digit_en;
  logic          scan_tick;

  seven_segment_scanner #(
    .NUM_DIGITS(ND),
    .REFRESH_DIV(DIV),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .data(data),
    .blank(blank),
    .dp(dp),
    .lz_suppress(lz_suppress),
    .seg(seg),
    .seg_dp(seg_dp),
    .digit_en(digit_en),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  // Active-high expectations per digit index; pins are the complement
  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      blank;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] seg_hi;
    logic [3:0]      dp_hi;
    logic [3:0]      en_hi;
  } vec_t;

  typedef struct packed {
    logic [6:0] seg;
    logic       sdp;
    logic [3:0] en;
    logic       tick;
  } exp_t;

  vec_t  vecs [NV];
  exp_t  sb_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [6:0] s, input logic d, input logic [3:0] e, input logic t);
    exp_t x;
    x.seg  = s;
    x.sdp  = d;
    x.en   = e;
    x.tick = t;
    sb_q.push_back(x);
  endtask

  task automatic check_pop(input string name);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    e = sb_q.pop_front();
    if (seg !== e.seg || seg_dp !== e.sdp || digit_en !== e.en || scan_tick !== e.tick) begin
      n_bad++;
      $display("FAIL %s: got seg=%b dp=%b en=%b tick=%b, expected seg=%b dp=%b en=%b tick=%b",
               name, seg, seg_dp, digit_en, scan_tick, e.seg, e.sdp, e.en, e.tick);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int order [4];
    logic [3:0] oh;
    order = '{1, 2, 3, 0};

    //                data      blank  dp     lz    {d3, d2, d1, d0} active-high segments               dp_hi  en_hi
    vecs[0] = '{16'h1234, 4'h0, 4'h0, 1'b0, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0000, 4'b1111};
    vecs[1] = '{16'h0005, 4'h0, 4'h2, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1011011}, 4'b0010, 4'b0011};
    vecs[2] = '{16'h0000, 4'h0, 4'h0, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0000, 4'b0001};
    vecs[3] = '{16'hABCD, 4'h4, 4'h0, 1'b0, {7'b1110111, 7'b0000000, 7'b1001110, 7'b0111101}, 4'b0000, 4'b1011};
    vecs[4] = '{16'hABCD, 4'h4, 4'h5, 1'b0, {7'b1110111, 7'b0000000, 7'b1001110, 7'b0111101}, 4'b0001, 4'b1011};
    vecs[5] = '{16'h0F00, 4'h0, 4'h8, 1'b1, {7'b0000000, 7'b1000111, 7'b1111110, 7'b1111110}, 4'b1000, 4'b1111};
    vecs[6] = '{16'h0000, 4'h0, 4'hF, 1'b0, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, 4'b1111, 4'b1111};
    vecs[7] = '{16'h89EB, 4'h0, 4'h0, 1'b0, {7'b1111111, 7'b1111011, 7'b1001111, 7'b0011111}, 4'b0000, 4'b1111};
    vecs[8] = '{16'h0067, 4'h0, 4'h0, 1'b0, {7'b1111110, 7'b1111110, 7'b1011111, 7'b1110000}, 4'b0000, 4'b1111};

    // Reset held with load asserted: shadow must not capture, pins inactive
    reset = 1'b1;
    load  = 1'b1;
    data  = 16'h1234;
    step();
    step();
    step();
    push_exp(7'h7F, 1'b1, 4'hF, 1'b0);
    check_pop("reset_hold");

    // Release with load still high: digit 0 shows "4" two edges later
    reset = 1'b0;
    step();
    load = 1'b0;
    step();
    push_exp(~7'b0110011, 1'b1, 4'b1110, 1'b0);
    check_pop("release_digit0");

    // Load on the 3->0 wrap edge (edge 16): first digit-0 cycle shows the new value
    repeat (13) step();
    load = 1'b1;
    data = 16'hFFFF;
    push_exp(~7'b0110000, 1'b1, 4'b0111, 1'b1);
    push_exp(~7'b1000111, 1'b1, 4'b1110, 1'b0);
    step();
    load = 1'b0;
    check_pop("wrap_load_old_digit3");
    step();
    check_pop("wrap_load_new_digit0");

    // Reset in the middle of digit 2
    repeat (9) step();
    push_exp(~7'b1000111, 1'b1, 4'b1011, 1'b0);
    check_pop("mid_digit2");
    #1;
    reset = 1'b1;
    #1;
    push_exp(7'h7F, 1'b1, 4'hF, 1'b0);
    check_pop("async_reset");
    step();
    reset = 1'b0;
    for (int j = 0; j < 4; j++) push_exp(~7'b1111110, 1'b1, 4'b1110, (j == 3));
    push_exp(~7'b1111110, 1'b1, 4'b1101, 1'b0);
    for (int j = 0; j < 5; j++) begin
      step();
      check_pop($sformatf("post_reset cyc%0d", j));
    end

    // Table vectors: resync by reset, load on first edge, check digits 1,2,3,0 every cycle
    for (int v = 0; v < int'(NV); v++) begin
      reset = 1'b1;
      step();
      reset       = 1'b0;
      load        = 1'b1;
      data        = vecs[v].data;
      blank       = vecs[v].blank;
      dp          = vecs[v].dp;
      lz_suppress = vecs[v].lz;
      for (int d = 0; d < 4; d++) begin
        int k;
        k  = order[d];
        oh = 4'b0001 << k;
        for (int j = 0; j < int'(DIV); j++) begin
          push_exp(~vecs[v].seg_hi[k], ~vecs[v].dp_hi[k],
                   vecs[v].en_hi[k] ? ~oh : 4'hF, (j == int'(DIV) - 1));
        end
      end
      step();
      load = 1'b0;
      repeat (3) step();
      for (int d = 0; d < 4; d++) begin
        for (int j = 0; j < int'(DIV); j++) begin
          step();
          check_pop($sformatf("vec%0d dig%0d cyc%0d", v, order[d], j));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
